// File: rtl/clock_pkg.sv
// Shared types, BCD limits and digit-position mapping for the clock entry controller.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } stateT;

  typedef enum logic [1:0] {
    POS_HOUR_TENS  = 2'd0,
    POS_HOUR_UNITS = 2'd1,
    POS_TENS_59    = 2'd2,
    POS_UNITS      = 2'd3
  } posT;

  localparam int unsigned BCD_W                = 4;
  localparam int unsigned HOUR_TENS_MAX        = 2;
  localparam int unsigned HOUR_UNITS_MAX_AT_20 = 3;
  localparam int unsigned TENS_59_MAX          = 5;
  localparam int unsigned DIGIT_MAX            = 9;

  // Top two digits are hours; below that, odd indices are base-60 tens, even are units.
  function automatic posT digitPos(input int unsigned idx, input int unsigned numDigits);
    if (idx == numDigits - 1) begin
      return POS_HOUR_TENS;
    end else if (idx == numDigits - 2) begin
      return POS_HOUR_UNITS;
    end else if (idx[0]) begin
      return POS_TENS_59;
    end else begin
      return POS_UNITS;
    end
  endfunction

endpackage

// File: rtl/clock_digit_entry_if.sv
// Keypad/counter-side bundle of the digit entry controller.
interface clock_digit_entry_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(NUM_DIGITS);

  logic          start_time;
  logic          start_alarm;
  logic          key_valid;
  logic [3:0]    key_digit;
  logic          cancel;
  logic [DW-1:0] time_cur;
  logic [DW-1:0] time_set;
  logic          time_load;
  logic [DW-1:0] alarm_q;
  logic [DW-1:0] edit_buf;
  logic          edit_active;
  logic          edit_is_alarm;
  logic [CW-1:0] cursor;
  logic          reject;
  logic          timeout;

  modport master (
    output start_time, start_alarm, key_valid, key_digit, cancel, time_cur,
    input  time_set, time_load, alarm_q, edit_buf, edit_active, edit_is_alarm,
           cursor, reject, timeout
  );

  modport slave (
    input  start_time, start_alarm, key_valid, key_digit, cancel, time_cur,
    output time_set, time_load, alarm_q, edit_buf, edit_active, edit_is_alarm,
           cursor, reject, timeout
  );
endinterface

// File: rtl/digit_limit_check.sv
// Combinational legality check of a candidate BCD digit at a given buffer position.
module digit_limit_check
  import clock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  localparam int unsigned CW = $clog2(NUM_DIGITS)
) (
  input  logic [CW-1:0]    idx,
  input  logic [BCD_W-1:0] digit,
  input  logic [BCD_W-1:0] hourTens,
  output logic             legal
);

  logic [BCD_W-1:0] limit;

  // Upper bound for the position; hour units narrow to 0-3 once hour tens is 2.
  always_comb begin
    limit = BCD_W'(DIGIT_MAX);
    unique case (digitPos(32'(idx), NUM_DIGITS))
      POS_HOUR_TENS:  limit = BCD_W'(HOUR_TENS_MAX);
      POS_HOUR_UNITS: limit = (hourTens == BCD_W'(HOUR_TENS_MAX)) ?
                              BCD_W'(HOUR_UNITS_MAX_AT_20) : BCD_W'(DIGIT_MAX);
      POS_TENS_59:    limit = BCD_W'(TENS_59_MAX);
      POS_UNITS:      limit = BCD_W'(DIGIT_MAX);
      default:        limit = BCD_W'(DIGIT_MAX);
    endcase
    legal = (digit <= limit);
  end

endmodule

// File: rtl/clock_digit_entry.sv
// Keypad edit session for time/alarm: shadow buffer, MSB-first entry, atomic commit.
module clock_digit_entry
  import clock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input logic               clk,
  input logic               rst,
  clock_digit_entry_if.slave bus
);

  localparam int unsigned DW = BCD_W * NUM_DIGITS;
  localparam int unsigned CW = $clog2(NUM_DIGITS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TOP_IDX = CW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  stateT                             state;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] editBuf;
  logic [CW-1:0]                     cursor;
  logic [TW-1:0]                     idleCnt;
  logic [DW-1:0]                     alarmQ;
  logic [DW-1:0]                     timeSet;
  logic                              timeLoad;
  logic                              reject;
  logic                              timeout;
  logic                              editActive;
  logic                              editIsAlarm;
  logic                              digitLegal;

  digit_limit_check #(
    .NUM_DIGITS(NUM_DIGITS)
  ) uLimit (
    .idx      (cursor),
    .digit    (bus.key_digit),
    .hourTens (editBuf[NUM_DIGITS-1]),
    .legal    (digitLegal)
  );

  // Session FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      editBuf     <= '0;
      cursor      <= '0;
      idleCnt     <= '0;
      alarmQ      <= '0;
      timeSet     <= '0;
      timeLoad    <= 1'b0;
      reject      <= 1'b0;
      timeout     <= 1'b0;
      editActive  <= 1'b0;
      editIsAlarm <= 1'b0;
    end else begin
      timeLoad <= 1'b0;
      reject   <= 1'b0;
      timeout  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_time || bus.start_alarm) begin
            state       <= EDIT;
            editActive  <= 1'b1;
            editIsAlarm <= !bus.start_time;
            editBuf     <= bus.start_time ? bus.time_cur : alarmQ;
            cursor      <= TOP_IDX;
            idleCnt     <= '0;
          end
        end
        EDIT: begin
          if (bus.cancel) begin
            state      <= IDLE;
            editActive <= 1'b0;
          end else if (bus.key_valid) begin
            idleCnt <= '0;
            if (digitLegal) begin
              editBuf[cursor] <= bus.key_digit;
              if (cursor == '0) begin
                state      <= COMMIT;
                editActive <= 1'b0;
              end else begin
                cursor <= cursor - CW'(1);
              end
            end else begin
              reject <= 1'b1;
            end
          end else if (idleCnt == IDLE_LAST) begin
            timeout    <= 1'b1;
            state      <= IDLE;
            editActive <= 1'b0;
          end else begin
            idleCnt <= idleCnt + TW'(1);
          end
        end
        COMMIT: begin
          if (editIsAlarm) begin
            alarmQ <= editBuf;
          end else begin
            timeSet  <= editBuf;
            timeLoad <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          editActive <= 1'b0;
        end
      endcase
    end
  end

  assign bus.time_set      = timeSet;
  assign bus.time_load     = timeLoad;
  assign bus.alarm_q       = alarmQ;
  assign bus.edit_buf      = editBuf;
  assign bus.edit_active   = editActive;
  assign bus.edit_is_alarm = editIsAlarm;
  assign bus.cursor        = cursor;
  assign bus.reject        = reject;
  assign bus.timeout       = timeout;

endmodule

// File: tb/tb_clock_digit_entry.sv
// Scoreboard bench: a 4-digit instance (short timeout) and a 6-digit instance.
module tb_clock_digit_entry;

  localparam logic [2:0] K_LOAD  = 3'd0;
  localparam logic [2:0] K_ALARM = 3'd1;
  localparam logic [2:0] K_REJ   = 3'd2;
  localparam logic [2:0] K_TO    = 3'd3;
  localparam logic [2:0] K_NONE  = 3'd7;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } evT;

  logic clk = 1'b0;
  logic rst4;
  logic rst6;
  logic monOn = 1'b0;
  logic [15:0] prevAlarm4;
  int nCmp = 0;
  int nBad = 0;
  evT q4[$];
  evT q6[$];

  always #5 clk = ~clk;

  clock_digit_entry_if #(.NUM_DIGITS(4)) ifc4();
  clock_digit_entry_if #(.NUM_DIGITS(6)) ifc6();

  clock_digit_entry #(.NUM_DIGITS(4), .TIMEOUT_CYCLES(8)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (ifc4.slave)
  );

  clock_digit_entry #(.NUM_DIGITS(6), .TIMEOUT_CYCLES(16)) dut6 (
    .clk (clk),
    .rst (rst6),
    .bus (ifc6.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic popChk(input bit six, input logic [2:0] kind, input logic [31:0] val, input string tag);
    evT e;
    e = '{kind: K_NONE, val: 32'h0};
    if (six) begin
      if (q6.size() != 0) e = q6.pop_front();
    end else begin
      if (q4.size() != 0) e = q4.pop_front();
    end
    chk({tag, "_kind"}, 32'(kind), 32'(e.kind));
    chk({tag, "_val"}, val, e.val);
  endtask

  // Output monitors: every pulse or alarm change must match the next expected event.
  always @(negedge clk) begin
    if (monOn) begin
      if (ifc4.time_load) popChk(1'b0, K_LOAD, 32'(ifc4.time_set), "d4_load");
      if (ifc4.alarm_q !== prevAlarm4) popChk(1'b0, K_ALARM, 32'(ifc4.alarm_q), "d4_alarm");
      if (ifc4.reject) popChk(1'b0, K_REJ, 32'(ifc4.cursor), "d4_reject");
      if (ifc4.timeout) popChk(1'b0, K_TO, 32'(ifc4.edit_active), "d4_timeout");
      if (ifc6.time_load) popChk(1'b1, K_LOAD, 32'(ifc6.time_set), "d6_load");
      if (ifc6.reject) popChk(1'b1, K_REJ, 32'(ifc6.cursor), "d6_reject");
      if (ifc6.timeout) popChk(1'b1, K_TO, 32'(ifc6.edit_active), "d6_timeout");
    end
    prevAlarm4 <= ifc4.alarm_q;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic key4(input logic [3:0] d);
    ifc4.key_valid = 1'b1;
    ifc4.key_digit = d;
    cyc();
    ifc4.key_valid = 1'b0;
  endtask

  task automatic key6(input logic [3:0] d);
    ifc6.key_valid = 1'b1;
    ifc6.key_digit = d;
    cyc();
    ifc6.key_valid = 1'b0;
  endtask

  task automatic start4(input bit t, input bit a);
    ifc4.start_time  = t;
    ifc4.start_alarm = a;
    cyc();
    ifc4.start_time  = 1'b0;
    ifc4.start_alarm = 1'b0;
  endtask

  task automatic cancel4();
    ifc4.cancel = 1'b1;
    cyc();
    ifc4.cancel = 1'b0;
  endtask

  initial begin
    ifc4.start_time = 1'b0; ifc4.start_alarm = 1'b0; ifc4.key_valid = 1'b0;
    ifc4.key_digit = 4'd0; ifc4.cancel = 1'b0; ifc4.time_cur = 16'h0000;
    ifc6.start_time = 1'b0; ifc6.start_alarm = 1'b0; ifc6.key_valid = 1'b0;
    ifc6.key_digit = 4'd0; ifc6.cancel = 1'b0; ifc6.time_cur = 24'h000000;
    rst4 = 1'b1;
    rst6 = 1'b1;
    repeat (3) cyc();

    // Reset values
    chk("rst_alarm_q", 32'(ifc4.alarm_q), 32'h0);
    chk("rst_time_set", 32'(ifc4.time_set), 32'h0);
    chk("rst_edit_buf", 32'(ifc4.edit_buf), 32'h0);
    chk("rst_cursor", 32'(ifc4.cursor), 32'h0);
    chk("rst_edit_active", 32'(ifc4.edit_active), 32'h0);
    chk("rst_is_alarm", 32'(ifc4.edit_is_alarm), 32'h0);
    chk("rst_time_load", 32'(ifc4.time_load), 32'h0);
    chk("rst_reject", 32'(ifc4.reject), 32'h0);
    chk("rst_timeout", 32'(ifc4.timeout), 32'h0);
    rst4 = 1'b0;
    rst6 = 1'b0;
    cyc();
    monOn = 1'b1;

    // IDLE ignores keys and cancel
    key4(4'd5);
    cancel4();
    chk("idle_active", 32'(ifc4.edit_active), 32'h0);
    chk("idle_buf", 32'(ifc4.edit_buf), 32'h0);

    // Alarm entry 07:30
    start4(1'b0, 1'b1);
    chk("t1_active", 32'(ifc4.edit_active), 32'h1);
    chk("t1_is_alarm", 32'(ifc4.edit_is_alarm), 32'h1);
    chk("t1_cursor", 32'(ifc4.cursor), 32'd3);
    key4(4'd0);
    key4(4'd7);
    chk("t1_cursor_mid", 32'(ifc4.cursor), 32'd1);
    chk("t1_buf_mid", 32'(ifc4.edit_buf), 32'h0700);
    key4(4'd3);
    q4.push_back('{kind: K_ALARM, val: 32'h0730});
    key4(4'd0);
    chk("t1_active_commit", 32'(ifc4.edit_active), 32'h0);
    chk("t1_alarm_pre", 32'(ifc4.alarm_q), 32'h0);
    cyc();
    chk("t1_alarm", 32'(ifc4.alarm_q), 32'h0730);
    chk("t1_no_load", 32'(ifc4.time_load), 32'h0);
    cyc();
    chk("t1_active_after", 32'(ifc4.edit_active), 32'h0);

    // Time entry 23:59 over 11:59
    ifc4.time_cur = 16'h1159;
    start4(1'b1, 1'b0);
    chk("t2_buf_load", 32'(ifc4.edit_buf), 32'h1159);
    chk("t2_is_alarm", 32'(ifc4.edit_is_alarm), 32'h0);
    key4(4'd2);
    key4(4'd3);
    key4(4'd5);
    q4.push_back('{kind: K_LOAD, val: 32'h2359});
    key4(4'd9);
    cyc();
    chk("t2_time_set", 32'(ifc4.time_set), 32'h2359);
    chk("t2_time_load", 32'(ifc4.time_load), 32'h1);
    cyc();
    chk("t2_load_once", 32'(ifc4.time_load), 32'h0);

    // Range rejects
    start4(1'b1, 1'b0);
    key4(4'd2);
    q4.push_back('{kind: K_REJ, val: 32'd2});
    key4(4'd4);
    chk("t3_reject_hu", 32'(ifc4.reject), 32'h1);
    chk("t3_cursor_hu", 32'(ifc4.cursor), 32'd2);
    key4(4'd3);
    chk("t3_accept", 32'(ifc4.reject), 32'h0);
    chk("t3_cursor_mt", 32'(ifc4.cursor), 32'd1);
    q4.push_back('{kind: K_REJ, val: 32'd1});
    key4(4'd6);
    chk("t3_reject_mt", 32'(ifc4.reject), 32'h1);
    q4.push_back('{kind: K_REJ, val: 32'd1});
    key4(4'd15);
    chk("t3_reject_15", 32'(ifc4.reject), 32'h1);
    chk("t3_buf", 32'(ifc4.edit_buf), 32'h2359);
    cancel4();
    chk("t3_cancel", 32'(ifc4.edit_active), 32'h0);

    // Cancel leaves alarm untouched
    start4(1'b0, 1'b1);
    chk("t4_buf_load", 32'(ifc4.edit_buf), 32'h0730);
    key4(4'd1);
    key4(4'd2);
    cancel4();
    chk("t4_active", 32'(ifc4.edit_active), 32'h0);
    chk("t4_alarm", 32'(ifc4.alarm_q), 32'h0730);
    start4(1'b0, 1'b1);
    key4(4'd1);
    ifc4.cancel = 1'b1;
    ifc4.key_valid = 1'b1;
    ifc4.key_digit = 4'd2;
    cyc();
    ifc4.cancel = 1'b0;
    ifc4.key_valid = 1'b0;
    chk("t4b_active", 32'(ifc4.edit_active), 32'h0);
    chk("t4b_buf", 32'(ifc4.edit_buf), 32'h1730);
    chk("t4b_cursor", 32'(ifc4.cursor), 32'd2);
    repeat (3) cyc();
    chk("t4b_alarm", 32'(ifc4.alarm_q), 32'h0730);

    // Timeout after 8 idle cycles; start ignored in EDIT
    start4(1'b1, 1'b0);
    key4(4'd2);
    repeat (3) cyc();
    start4(1'b0, 1'b1);
    repeat (3) cyc();
    chk("t5_no_timeout", 32'(ifc4.timeout), 32'h0);
    chk("t5_still_active", 32'(ifc4.edit_active), 32'h1);
    chk("t5_is_alarm", 32'(ifc4.edit_is_alarm), 32'h0);
    q4.push_back('{kind: K_TO, val: 32'h0});
    cyc();
    chk("t5_timeout", 32'(ifc4.timeout), 32'h1);
    chk("t5_active_off", 32'(ifc4.edit_active), 32'h0);
    cyc();
    chk("t5_timeout_once", 32'(ifc4.timeout), 32'h0);

    // Simultaneous starts: time wins
    start4(1'b1, 1'b1);
    chk("t6_is_alarm", 32'(ifc4.edit_is_alarm), 32'h0);
    chk("t6_buf", 32'(ifc4.edit_buf), 32'h1159);
    cancel4();

    // Six-digit entry 12:34:59 with a seconds-tens reject
    ifc6.start_time = 1'b1;
    cyc();
    ifc6.start_time = 1'b0;
    chk("d6_cursor", 32'(ifc6.cursor), 32'd5);
    key6(4'd1);
    key6(4'd2);
    key6(4'd3);
    key6(4'd4);
    q6.push_back('{kind: K_REJ, val: 32'd1});
    key6(4'd7);
    key6(4'd5);
    q6.push_back('{kind: K_LOAD, val: 32'h123459});
    key6(4'd9);
    cyc();
    chk("d6_time_set", 32'(ifc6.time_set), 32'h123459);
    chk("d6_time_load", 32'(ifc6.time_load), 32'h1);

    // Reset mid-session
    ifc6.start_time = 1'b1;
    cyc();
    ifc6.start_time = 1'b0;
    key6(4'd1);
    key6(4'd2);
    key6(4'd3);
    #2 rst6 = 1'b1;
    #1;
    chk("d6_rst_active", 32'(ifc6.edit_active), 32'h0);
    chk("d6_rst_cursor", 32'(ifc6.cursor), 32'h0);
    chk("d6_rst_buf", 32'(ifc6.edit_buf), 32'h0);
    chk("d6_rst_time_set", 32'(ifc6.time_set), 32'h0);
    chk("d6_rst_is_alarm", 32'(ifc6.edit_is_alarm), 32'h0);
    repeat (2) cyc();
    rst6 = 1'b0;
    repeat (20) cyc();
    chk("d6_post_rst_active", 32'(ifc6.edit_active), 32'h0);
    chk("d6_post_rst_time_set", 32'(ifc6.time_set), 32'h0);

    repeat (2) cyc();
    chk("q4_drain", 32'(q4.size()), 32'h0);
    chk("q6_drain", 32'(q6.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
